alu_issuer: RTL and testbench

ALU_ISSUER -- requirements
Module: alu_issuer

---
 rtl/alu_issuer.sv | 154 +++++++++++++++
 tb/tb_alu_issuer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issuer.sv
// Issues queued ALU commands one at a time: a small command FIFO feeds a
// four-state sequencer that drives the ALU, captures its result and holds it until consumed.
module alu_issuer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_a,
  input  logic [31:0] cmd_b,
  input  logic [1:0]  cmd_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [1:0]  alu_op,
  output logic        alu_en,
  input  logic [31:0] alu_result,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [7:0]  rsp_seq
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 66;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t        state_r;
  state_t        next_state_s;
  logic [EW-1:0] fifo_mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic [CW-1:0] count_next_s;
  logic [EW-1:0] head_s;
  logic          push_s;
  logic          pop_s;
  logic          cmd_ready_r;
  logic          alu_en_r;
  logic [31:0]   alu_a_r;
  logic [31:0]   alu_b_r;
  logic [1:0]    alu_op_r;
  logic          rsp_valid_r;
  logic [31:0]   rsp_data_r;
  logic [7:0]    rsp_seq_r;

  // cmd_ready_r already reflects count < DEPTH, so a full FIFO never accepts
  assign push_s = cmd_valid && cmd_ready_r;
  assign pop_s  = (state_r == ISSUE);
  assign head_s = fifo_mem_r[rd_ptr_r];

  assign cmd_ready = cmd_ready_r;
  assign alu_en    = alu_en_r;
  assign alu_a     = alu_a_r;
  assign alu_b     = alu_b_r;
  assign alu_op    = alu_op_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_data  = rsp_data_r;
  assign rsp_seq   = rsp_seq_r;

  // FIFO occupancy after this edge's push/pop
  always_comb begin
    count_next_s = count_r;
    if (push_s && !pop_s) begin
      count_next_s = count_r + CW'(1'b1);
    end else if (pop_s && !push_s) begin
      count_next_s = count_r - CW'(1'b1);
    end else begin
      count_next_s = count_r;
    end
  end

  // Sequencer next state; count is sampled before this edge's push
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (count_r != {CW{1'b0}}) next_state_s = ISSUE;
        else                       next_state_s = IDLE;
      end
      ISSUE: next_state_s = WAIT;
      WAIT:  next_state_s = RESP;
      RESP: begin
        if (rsp_ready) begin
          if (count_r != {CW{1'b0}}) next_state_s = ISSUE;
          else                       next_state_s = IDLE;
        end else begin
          next_state_s = RESP;
        end
      end
      default: next_state_s = IDLE;
    endcase
  end

  // Sequencer state register
  always_ff @(posedge clk) begin
    if (reset) state_r <= IDLE;
    else       state_r <= next_state_s;
  end

  // FIFO storage; contents need no reset because occupancy gates every read
  always_ff @(posedge clk) begin
    if (push_s && !reset) fifo_mem_r[wr_ptr_r] <= {cmd_a, cmd_b, cmd_op};
  end

  // Pointers, occupancy and all registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r    <= {AW{1'b0}};
      rd_ptr_r    <= {AW{1'b0}};
      count_r     <= {CW{1'b0}};
      cmd_ready_r <= 1'b1;
      alu_en_r    <= 1'b0;
      alu_a_r     <= 32'd0;
      alu_b_r     <= 32'd0;
      alu_op_r    <= 2'd0;
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= 32'd0;
      rsp_seq_r   <= 8'd0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1'b1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      count_r     <= count_next_s;
      cmd_ready_r <= (count_next_s < FULL_CNT);
      // ALU drive is loaded one edge early so it is registered during ISSUE;
      // the head cannot move before ISSUE because only ISSUE pops.
      if (next_state_s == ISSUE) begin
        alu_en_r <= 1'b1;
        alu_a_r  <= head_s[65:34];
        alu_b_r  <= head_s[33:2];
        alu_op_r <= head_s[1:0];
      end else begin
        alu_en_r <= 1'b0;
        alu_a_r  <= 32'd0;
        alu_b_r  <= 32'd0;
        alu_op_r <= 2'd0;
      end
      if (state_r == WAIT) begin
        rsp_data_r  <= alu_result;
        rsp_valid_r <= 1'b1;
      end else if (state_r == RESP && rsp_ready) begin
        rsp_valid_r <= 1'b0;
        rsp_seq_r   <= rsp_seq_r + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_alu_issuer.sv
// Randomised bench for alu_issuer with a reference registered ALU, an
// acceptance-side scoreboard and an independent response monitor.
module tb_alu_issuer;
  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_a;
  logic [31:0] cmd_b;
  logic [1:0]  cmd_op;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [1:0]  alu_op;
  logic        alu_en;
  logic [31:0] alu_result = 32'd0;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [7:0]  rsp_seq;

  typedef struct packed {
    logic [31:0] data;
    logic [7:0]  seq;
  } exp_t;

  exp_t exp_q[$];
  exp_t ent_acc;
  exp_t ent_chk;
  int   hs_cyc[$];
  int   acc_cnt = 0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  logic rnd_done;

  always #5 clk = ~clk;

  alu_issuer #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_en(alu_en),
    .alu_result(alu_result), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_seq(rsp_seq)
  );

  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [1:0] op);
    case (op)
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a & b;
      default: return a ^ b;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference ALU: result registered one edge after alu_en
  always @(posedge clk) begin
    if (alu_en) alu_result <= alu_f(alu_a, alu_b, alu_op);
    cyc <= cyc + 1;
  end

  // Acceptance side: every accepted command will produce the n-th response since reset
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      acc_cnt <= 0;
    end else if (cmd_valid && cmd_ready) begin
      ent_acc.data = alu_f(cmd_a, cmd_b, cmd_op);
      ent_acc.seq  = acc_cnt[7:0];
      exp_q.push_back(ent_acc);
      acc_cnt <= acc_cnt + 1;
    end
  end

  // Response monitor: a handshake completes on the next rising edge
  always @(negedge clk) begin
    if (reset) begin
      hs_cyc.delete();
    end else if (rsp_valid && rsp_ready) begin
      chk("rsp_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        ent_chk = exp_q.pop_front();
        chk("rsp_data", rsp_data, ent_chk.data);
        chk("rsp_seq", 32'(rsp_seq), 32'(ent_chk.seq));
      end
      hs_cyc.push_back(cyc);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    tick(n);
    reset = 1'b0;
  endtask

  task automatic wait_accept();
    int   i = 0;
    logic done = 1'b0;
    cmd_valid = 1'b1;
    while (!done && i < 300) begin
      @(negedge clk);
      done = cmd_ready;
      @(posedge clk);
      #1;
      i++;
    end
    cmd_valid = 1'b0;
    chk("accept_timeout", 32'(done), 32'd1);
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
    cmd_a  = a;
    cmd_b  = b;
    cmd_op = op;
    wait_accept();
  endtask

  task automatic wait_rsp_valid(input int budget);
    int i = 0;
    while (!rsp_valid && i < budget) begin
      tick(1);
      i++;
    end
    chk("rsp_valid_timeout", 32'(rsp_valid), 32'd1);
  endtask

  task automatic wait_drain(input int budget);
    int i = 0;
    while (exp_q.size() != 0 && i < budget) begin
      tick(1);
      i++;
    end
    chk("drain", 32'(exp_q.size()), 32'd0);
    tick(1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_a     = 32'd0;
    cmd_b     = 32'd0;
    cmd_op    = 2'd0;
    rsp_ready = 1'b0;
    rnd_done  = 1'b0;
    tick(2);
    reset = 1'b0;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_alu_en", 32'(alu_en), 32'd0);
    chk("rst_rsp_seq", 32'(rsp_seq), 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_op", 32'(alu_op), 32'd0);

    // Single op latency: accept T0, alu_en after T1, rsp_valid after T3
    rsp_ready = 1'b1;
    cmd_a = 32'd5; cmd_b = 32'd3; cmd_op = 2'd0; cmd_valid = 1'b1;
    tick(1);
    cmd_valid = 1'b0;
    chk("lat_t0_alu_en", 32'(alu_en), 32'd0);
    tick(1);
    chk("lat_t1_alu_en", 32'(alu_en), 32'd1);
    chk("lat_t1_alu_a", alu_a, 32'd5);
    chk("lat_t1_alu_b", alu_b, 32'd3);
    chk("lat_t1_alu_op", 32'(alu_op), 32'd0);
    tick(1);
    chk("lat_t2_alu_en", 32'(alu_en), 32'd0);
    chk("lat_t2_alu_a", alu_a, 32'd0);
    chk("lat_t2_rsp_valid", 32'(rsp_valid), 32'd0);
    tick(1);
    chk("lat_t3_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("lat_t3_rsp_data", rsp_data, 32'd8);
    chk("lat_t3_rsp_seq", 32'(rsp_seq), 32'd0);
    tick(1);
    chk("lat_t4_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("lat_t4_rsp_seq", 32'(rsp_seq), 32'd1);

    // Fill: one op parked in RESP, four more fill the FIFO, fifth is held off
    do_reset(2);
    rsp_ready = 1'b0;
    send(32'd100, 32'd1, 2'd0);
    wait_rsp_valid(10);
    for (int i = 1; i <= 4; i++) send(32'(i), 32'd10, 2'd0);
    chk("fill_full", 32'(cmd_ready), 32'd0);
    cmd_a = 32'd5; cmd_b = 32'd10; cmd_op = 2'd0; cmd_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("fill_held_ready", 32'(cmd_ready), 32'd0);
      chk("fill_held_seq", 32'(rsp_seq), 32'd0);
    end
    rsp_ready = 1'b1;
    wait_accept();
    wait_drain(100);
    chk("fill_final_seq", 32'(rsp_seq), 32'd6);
    chk("fill_rsp_count", 32'(hs_cyc.size()), 32'd6);
    if (hs_cyc.size() >= 3) chk("throughput", 32'(hs_cyc[2] - hs_cyc[1]), 32'd3);

    // Backpressure: response held stable for 10 cycles
    do_reset(1);
    rsp_ready = 1'b0;
    send(32'd7, 32'd9, 2'd1);
    wait_rsp_valid(10);
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_rsp_data", rsp_data, 32'hFFFF_FFFE);
      chk("bp_rsp_seq", 32'(rsp_seq), 32'd0);
      chk("bp_alu_en", 32'(alu_en), 32'd0);
    end
    rsp_ready = 1'b1;
    wait_drain(20);

    // Reset while in WAIT with two ops queued
    do_reset(1);
    rsp_ready = 1'b1;
    send(32'd1, 32'd1, 2'd0);
    send(32'd2, 32'd2, 2'd0);
    send(32'd3, 32'd3, 2'd0);
    do_reset(1);
    for (int i = 0; i < 5; i++) begin
      chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("midrst_alu_en", 32'(alu_en), 32'd0);
      tick(1);
    end
    rsp_ready = 1'b0;
    send(32'd20, 32'd22, 2'd3);
    wait_rsp_valid(10);
    chk("midrst_seq", 32'(rsp_seq), 32'd0);
    chk("midrst_data", rsp_data, 32'd2);
    rsp_ready = 1'b1;
    wait_drain(20);

    // Sequence wrap over 257 random ops
    do_reset(1);
    rsp_ready = 1'b1;
    for (int i = 0; i < 257; i++) send($urandom, $urandom, 2'($urandom_range(0, 3)));
    wait_drain(2000);
    chk("wrap_count", 32'(hs_cyc.size()), 32'd257);
    chk("wrap_final_seq", 32'(rsp_seq), 32'd1);

    // Random traffic with random consumer backpressure
    do_reset(1);
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          tick($urandom_range(0, 3));
          send($urandom, $urandom, 2'($urandom_range(0, 3)));
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          rsp_ready = 1'($urandom_range(0, 1));
          tick(1);
        end
      end
    join
    rsp_ready = 1'b1;
    wait_drain(500);
    chk("rand_count", 32'(hs_cyc.size()), 32'd60);
    chk("rand_final_seq", 32'(rsp_seq), 32'd60);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
